// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller.
//   state_t         : session sequencer states
//   OP_*            : front-panel operation codes
//   ERR_*           : values reported on error_code with an error pulse
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PIN_WAIT,
    MENU,
    DISPENSE,
    EJECT
  } state_t;

  localparam logic [1:0] OP_BAL  = 2'b00;
  localparam logic [1:0] OP_WDR  = 2'b01;
  localparam logic [1:0] OP_DEP  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_PIN  = 3'd1;
  localparam logic [2:0] ERR_LOCKED   = 3'd2;
  localparam logic [2:0] ERR_INSUFF   = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
  localparam logic [2:0] ERR_LIMIT    = 3'd6;

endpackage

// File: rtl/atm_timeout_timer.sv
// Idle-cycle counter used for session timeouts.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : return count to zero (has priority over en)
//   en         : count one cycle
//   expire     : high for the single cycle in which count reaches LIMIT-1
//                while counting; the count moves past it on the next edge
module atm_timeout_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + W'(1);
  end

  assign expire = en & ~clr & (count == W'(LIMIT - 1));

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM card-session sequencer: card detect, PIN check with lockout, operation
// menu (balance/withdraw/deposit/exit), dispenser handshake, card eject/retain.
// Owns the account balance register. All outputs are registered.
// Inputs : clk, reset (async active-low), card_in, pin_valid/pin_value,
//          stored_pin, op_valid/op_code/amount, dispense_ack
// Outputs: dispense_req/cash_amount, deposit_complete, show_balance/
//          balance_out, ready, session_active, card_eject, card_retain,
//          error/error_code
// Build option: define ATM_SESSION_LIMIT_EN to add the per-session
// withdrawal limit (parameter SESSION_LIMIT, error code 6).
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_WIDTH      = 16,
  parameter int AMT_WIDTH      = 16,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BAL_INIT       = 0
`ifdef ATM_SESSION_LIMIT_EN
  , parameter int SESSION_LIMIT = 500
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 card_in,
  input  logic                 pin_valid,
  input  logic [PIN_WIDTH-1:0] pin_value,
  input  logic [PIN_WIDTH-1:0] stored_pin,
  input  logic                 op_valid,
  input  logic [1:0]           op_code,
  input  logic [AMT_WIDTH-1:0] amount,
  input  logic                 dispense_ack,
  output logic                 dispense_req,
  output logic [AMT_WIDTH-1:0] cash_amount,
  output logic                 deposit_complete,
  output logic [AMT_WIDTH-1:0] balance_out,
  output logic                 show_balance,
  output logic                 ready,
  output logic                 session_active,
  output logic                 card_eject,
  output logic                 card_retain,
  output logic                 error,
  output logic [2:0]           error_code
);

  localparam logic [3:0] MAX_T = 4'(MAX_PIN_TRIES);

  state_t               state, state_nx;
  logic [AMT_WIDTH-1:0] balance, balance_nx, cash_nx, balout_nx;
  logic [2:0]           tries, tries_nx, code_nx;
  logic                 show_nx, dep_nx, ret_nx, err_nx;
  logic                 timed, expire;
  logic [AMT_WIDTH:0]   dep_sum;

`ifdef ATM_SESSION_LIMIT_EN
  logic [AMT_WIDTH:0]   accum, accum_nx;
  logic [AMT_WIDTH+1:0] lim_sum;
  assign lim_sum = {1'b0, accum} + {2'b00, amount};
`endif

  assign dep_sum = {1'b0, balance} + {1'b0, amount};
  assign timed   = (state == PIN_WAIT) || (state == MENU) || (state == DISPENSE);

  // Every entry into a timed state coincides with a strobe or comes from an
  // untimed state, so clearing on strobes and outside timed states is enough.
  atm_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (pin_valid | op_valid | dispense_ack | ~timed),
    .en     (timed),
    .expire (expire)
  );

  always_comb begin
    state_nx   = state;
    balance_nx = balance;
    cash_nx    = cash_amount;
    balout_nx  = balance_out;
    tries_nx   = tries;
    show_nx    = 1'b0;
    dep_nx     = 1'b0;
    ret_nx     = 1'b0;
    err_nx     = 1'b0;
    code_nx    = ERR_NONE;
`ifdef ATM_SESSION_LIMIT_EN
    accum_nx   = accum;
`endif
    case (state)
      IDLE: begin
        if (card_in) begin
          state_nx = PIN_WAIT;
          tries_nx = '0;
`ifdef ATM_SESSION_LIMIT_EN
          accum_nx = '0;
`endif
        end
      end
      PIN_WAIT: begin
        if (!card_in) begin
          state_nx = IDLE;
        end else if (pin_valid) begin
          if (pin_value == stored_pin) begin
            state_nx = MENU;
            tries_nx = '0;
          end else if (({1'b0, tries} + 4'd1) < MAX_T) begin
            tries_nx = tries + 3'd1;
            err_nx   = 1'b1;
            code_nx  = ERR_BAD_PIN;
          end else begin
            ret_nx   = 1'b1;
            err_nx   = 1'b1;
            code_nx  = ERR_LOCKED;
            state_nx = IDLE;
          end
        end else if (expire) begin
          err_nx   = 1'b1;
          code_nx  = ERR_TIMEOUT;
          state_nx = EJECT;
        end
      end
      MENU: begin
        if (!card_in) begin
          state_nx = IDLE;
        end else if (op_valid) begin
          case (op_code)
            OP_BAL: begin
              show_nx   = 1'b1;
              balout_nx = balance;
            end
            OP_WDR: begin
              if (amount == '0) begin
                state_nx = MENU;
              end else if (amount > balance) begin
                err_nx  = 1'b1;
                code_nx = ERR_INSUFF;
`ifdef ATM_SESSION_LIMIT_EN
              end else if (lim_sum > (AMT_WIDTH+2)'(SESSION_LIMIT)) begin
                err_nx  = 1'b1;
                code_nx = ERR_LIMIT;
`endif
              end else begin
                state_nx = DISPENSE;
                cash_nx  = amount;
              end
            end
            OP_DEP: begin
              if (dep_sum[AMT_WIDTH]) begin
                err_nx  = 1'b1;
                code_nx = ERR_OVERFLOW;
              end else begin
                balance_nx = dep_sum[AMT_WIDTH-1:0];
                dep_nx     = 1'b1;
              end
            end
            OP_EXIT: state_nx = EJECT;
          endcase
        end else if (expire) begin
          err_nx   = 1'b1;
          code_nx  = ERR_TIMEOUT;
          state_nx = EJECT;
        end
      end
      DISPENSE: begin
        if (dispense_ack) begin
          balance_nx = balance - cash_amount;
          state_nx   = MENU;
`ifdef ATM_SESSION_LIMIT_EN
          accum_nx   = accum + {1'b0, cash_amount};
`endif
        end else if (expire) begin
          err_nx   = 1'b1;
          code_nx  = ERR_TIMEOUT;
          state_nx = EJECT;
        end
      end
      EJECT: begin
        if (!card_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      balance          <= AMT_WIDTH'(BAL_INIT);
      tries            <= '0;
      cash_amount      <= '0;
      balance_out      <= '0;
      show_balance     <= 1'b0;
      deposit_complete <= 1'b0;
      card_retain      <= 1'b0;
      error            <= 1'b0;
      error_code       <= ERR_NONE;
      ready            <= 1'b1;
      session_active   <= 1'b0;
      card_eject       <= 1'b0;
      dispense_req     <= 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
      accum            <= '0;
`endif
    end else begin
      state            <= state_nx;
      balance          <= balance_nx;
      tries            <= tries_nx;
      cash_amount      <= cash_nx;
      balance_out      <= balout_nx;
      show_balance     <= show_nx;
      deposit_complete <= dep_nx;
      card_retain      <= ret_nx;
      error            <= err_nx;
      error_code       <= code_nx;
      ready            <= (state_nx == IDLE);
      session_active   <= (state_nx == PIN_WAIT) || (state_nx == MENU) ||
                          (state_nx == DISPENSE);
      card_eject       <= (state_nx == EJECT);
      dispense_req     <= (state_nx == DISPENSE);
`ifdef ATM_SESSION_LIMIT_EN
      accum            <= accum_nx;
`endif
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Testbench for atm_session_ctrl: directed scenarios followed by random
// stimulus, with every output checked each cycle against a session model.
module tb_atm_session_ctrl;

  localparam int PW   = 16;
  localparam int AW   = 16;
  localparam int MAXT = 3;
  localparam int TO   = 16;
  localparam int BI   = 100;
  localparam int AMAX = (1 << AW) - 1;
`ifdef ATM_SESSION_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif
  localparam int LIMIT = 500;

  localparam int S_IDLE = 0, S_PIN = 1, S_MENU = 2, S_DISP = 3, S_EJECT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          card_in, pin_valid, op_valid, dispense_ack;
  logic [PW-1:0] pin_value, stored_pin;
  logic [1:0]    op_code;
  logic [AW-1:0] amount;
  logic          dispense_req, deposit_complete, show_balance, ready;
  logic          session_active, card_eject, card_retain, error;
  logic [AW-1:0] cash_amount, balance_out;
  logic [2:0]    error_code;

  atm_session_ctrl #(
    .PIN_WIDTH(PW), .AMT_WIDTH(AW), .MAX_PIN_TRIES(MAXT),
    .TIMEOUT_CYCLES(TO), .BAL_INIT(BI)
  ) dut (
    .clk(clk), .reset(reset), .card_in(card_in), .pin_valid(pin_valid),
    .pin_value(pin_value), .stored_pin(stored_pin), .op_valid(op_valid),
    .op_code(op_code), .amount(amount), .dispense_ack(dispense_ack),
    .dispense_req(dispense_req), .cash_amount(cash_amount),
    .deposit_complete(deposit_complete), .balance_out(balance_out),
    .show_balance(show_balance), .ready(ready),
    .session_active(session_active), .card_eject(card_eject),
    .card_retain(card_retain), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // session model
  int m_st, m_bal, m_tries, m_tmr, m_cash, m_acc;
  logic [PW-1:0] cur_spin;
  logic          cur_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_bal = BI; m_tries = 0; m_tmr = 0; m_cash = 0; m_acc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    card_in = 1'b0; pin_valid = 1'b0; op_valid = 1'b0; dispense_ack = 1'b0;
    cur_c = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_active", session_active, 0);
    chk("rst_eject", card_eject, 0);
    chk("rst_req", dispense_req, 0);
    chk("rst_show", show_balance, 0);
    chk("rst_dep", deposit_complete, 0);
    chk("rst_retain", card_retain, 0);
    chk("rst_err", error, 0);
    chk("rst_code", error_code, 0);
    chk("rst_cash", cash_amount, 0);
    chk("rst_balout", balance_out, 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic tick(input logic c, input logic pv, input logic [PW-1:0] pval,
                      input logic ov, input logic [1:0] oc, input logic [AW-1:0] amt,
                      input logic ack);
    int ns, e_code, e_balout, a;
    bit e_show, e_dep, e_ret, e_err, act, tmo;
    @(negedge clk);
    card_in = c; pin_valid = pv; pin_value = pval; stored_pin = cur_spin;
    op_valid = ov; op_code = oc; amount = amt; dispense_ack = ack;
    cur_c = c;
    ns = m_st; e_show = 0; e_dep = 0; e_ret = 0; e_err = 0; e_code = 0;
    e_balout = m_bal; a = int'(amt);
    act = pv || ov || ack;
    tmo = !act && (m_tmr == TO - 1);
    case (m_st)
      S_IDLE: if (c) begin ns = S_PIN; m_tries = 0; m_acc = 0; end
      S_PIN: begin
        if (!c) ns = S_IDLE;
        else if (pv) begin
          if (pval == cur_spin) begin ns = S_MENU; m_tries = 0; end
          else if (m_tries + 1 < MAXT) begin m_tries++; e_err = 1; e_code = 1; end
          else begin e_ret = 1; e_err = 1; e_code = 2; ns = S_IDLE; end
        end else if (tmo) begin e_err = 1; e_code = 5; ns = S_EJECT; end
      end
      S_MENU: begin
        if (!c) ns = S_IDLE;
        else if (ov) begin
          if (oc == 2'd0) e_show = 1;
          else if (oc == 2'd1) begin
            if (a == 0) ns = S_MENU;
            else if (a > m_bal) begin e_err = 1; e_code = 3; end
            else if (LIM_EN && (m_acc + a > LIMIT)) begin e_err = 1; e_code = 6; end
            else begin ns = S_DISP; m_cash = a; end
          end else if (oc == 2'd2) begin
            if (m_bal + a > AMAX) begin e_err = 1; e_code = 4; end
            else begin m_bal = m_bal + a; e_dep = 1; end
          end else ns = S_EJECT;
        end else if (tmo) begin e_err = 1; e_code = 5; ns = S_EJECT; end
      end
      S_DISP: begin
        if (ack) begin m_bal = m_bal - m_cash; m_acc = m_acc + m_cash; ns = S_MENU; end
        else if (tmo) begin e_err = 1; e_code = 5; ns = S_EJECT; end
      end
      default: if (!c) ns = S_IDLE;
    endcase
    if (ns == m_st && !act && (ns == S_PIN || ns == S_MENU || ns == S_DISP)) m_tmr++;
    else m_tmr = 0;
    m_st = ns;
    @(posedge clk);
    #1;
    chk("ready", ready, ns == S_IDLE);
    chk("session_active", session_active, ns == S_PIN || ns == S_MENU || ns == S_DISP);
    chk("card_eject", card_eject, ns == S_EJECT);
    chk("dispense_req", dispense_req, ns == S_DISP);
    chk("show_balance", show_balance, e_show);
    chk("deposit_complete", deposit_complete, e_dep);
    chk("card_retain", card_retain, e_ret);
    chk("error", error, e_err);
    chk("error_code", error_code, e_code);
    if (e_show) chk("balance_out", balance_out, e_balout);
    if (ns == S_DISP) chk("cash_amount", cash_amount, m_cash);
  endtask

  task automatic idle_tick(input logic c);
    tick(c, 0, '0, 0, 2'd0, '0, 0);
  endtask

  task automatic op(input logic [1:0] oc, input logic [AW-1:0] amt);
    tick(1, 0, '0, 1, oc, amt, 0);
  endtask

  task automatic login();
    idle_tick(1);
    tick(1, 1, cur_spin, 0, 2'd0, '0, 0);
  endtask

  initial begin
    int quiet;
    logic c, pv, ov, ack;
    logic [PW-1:0] pval;
    logic [1:0] oc;
    logic [AW-1:0] amt;

    reset = 1'b0; card_in = 0; pin_valid = 0; op_valid = 0; dispense_ack = 0;
    pin_value = '0; op_code = '0; amount = '0; cur_spin = 16'h1234;
    stored_pin = cur_spin; cur_c = 0;
    model_reset();
    do_reset();

    // balance after reset
    login();
    op(2'd0, '0);
    chk("bal_init", balance_out, 100);
    op(2'd3, '0);
    idle_tick(0);

    // three wrong PINs: lockout
    idle_tick(1);
    tick(1, 1, 16'h1111, 0, 2'd0, '0, 0);
    chk("badpin1_code", error_code, 1);
    tick(1, 1, 16'h2222, 0, 2'd0, '0, 0);
    chk("badpin2_code", error_code, 1);
    tick(1, 1, 16'h3333, 0, 2'd0, '0, 0);
    chk("lock_code", error_code, 2);
    chk("lock_retain", card_retain, 1);
    chk("lock_ready", ready, 1);
    idle_tick(0);

    // insufficient funds, then a withdraw with a 5-cycle dispense
    login();
    op(2'd1, 16'd150);
    chk("insuff_code", error_code, 3);
    op(2'd1, 16'd40);
    chk("wdr_req", dispense_req, 1);
    for (int i = 0; i < 4; i++) begin
      idle_tick(1);
      chk("wdr_req_held", dispense_req, 1);
    end
    tick(1, 0, '0, 0, 2'd0, '0, 1);
    chk("wdr_req_drop", dispense_req, 0);
    op(2'd0, '0);
    chk("bal_after_wdr", balance_out, 60);

    // deposit overflow boundary
    op(2'd2, 16'd65440);
    op(2'd2, 16'd100);
    chk("ovf_code", error_code, 4);
    op(2'd0, '0);
    chk("bal_after_ovf", balance_out, 65500);
    op(2'd2, 16'd35);
    chk("dep_max", deposit_complete, 1);
    op(2'd0, '0);
    chk("bal_max", balance_out, 65535);

    // idle timeout in MENU
    for (int i = 1; i <= TO; i++) begin
      idle_tick(1);
      if (i < TO) chk("tmo_early", error, 0);
      else begin
        chk("tmo_code", error_code, 5);
        chk("tmo_eject", card_eject, 1);
      end
    end
    idle_tick(0);
    chk("tmo_idle", ready, 1);

    // reset while dispensing
    login();
    op(2'd1, 16'd1000);
    idle_tick(1);
    idle_tick(1);
    do_reset();
    login();
    op(2'd0, '0);
    chk("bal_after_rst", balance_out, 100);

`ifdef ATM_SESSION_LIMIT_EN
    // per-session withdrawal limit
    op(2'd2, 16'd900);
    op(2'd1, 16'd300);
    tick(1, 0, '0, 0, 2'd0, '0, 1);
    op(2'd1, 16'd300);
    chk("limit_code", error_code, 6);
    op(2'd0, '0);
    chk("bal_after_limit", balance_out, 700);
`endif
    op(2'd3, '0);
    idle_tick(0);

    // random sessions
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      c = cur_c;
      if (cur_c) begin
        if ($urandom_range(0, 63) == 0 || (m_st == S_EJECT && $urandom_range(0, 3) == 0))
          c = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        c = 1'b1;
        cur_spin = PW'($urandom_range(0, 15));
      end
      if (quiet == 0 && $urandom_range(0, 99) == 0) quiet = 20;
      pv   = (quiet == 0) && ($urandom_range(0, 4) == 0);
      pval = ($urandom_range(0, 1) == 0) ? cur_spin : PW'($urandom_range(0, 15));
      ov   = (quiet == 0) && ($urandom_range(0, 3) == 0);
      oc   = 2'($urandom_range(0, 3));
      amt  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, AMAX))
                                          : AW'($urandom_range(0, 300));
      ack  = (quiet == 0) && ($urandom_range(0, 5) == 0);
      if (quiet > 0) quiet--;
      tick(c, pv, pval, ov, oc, amt, ack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Session sequencer for the ATM controller. It runs one card session from start to end:
- card detect and PIN verification with retry lockout
- operation menu: balance, withdraw, deposit, exit
- cash-dispenser request/acknowledge handshake
- card eject or retain

It owns the account balance register and sits between the front-panel input logic and the dispenser/card-reader peripherals.

Parameters:
PIN_WIDTH, 16, width of entered and stored PIN
AMT_WIDTH, 16, width of amount and balance
MAX_PIN_TRIES, 3, wrong PINs allowed before card retained (1..7)
TIMEOUT_CYCLES, 1024, idle cycles allowed in PIN_WAIT/MENU/DISPENSE before abort
BAL_INIT, 0, balance value loaded at reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
card_in  in  1  level, card present in reader
pin_valid  in  1  one-cycle strobe, pin_value valid
pin_value  in  PIN_WIDTH  entered PIN
stored_pin  in  PIN_WIDTH  PIN read from card, stable while card_in=1
op_valid  in  1  one-cycle strobe, op_code/amount valid
op_code  in  2  00 balance, 01 withdraw, 10 deposit, 11 exit
amount  in  AMT_WIDTH  transaction amount
dispense_ack  in  1  dispenser done, one-cycle pulse
dispense_req  out  1  level, held until dispense_ack
cash_amount  out  AMT_WIDTH  amount to dispense, valid while dispense_req=1
deposit_complete  out  1  one-cycle pulse on accepted deposit
balance_out  out  AMT_WIDTH  current balance, valid while show_balance=1
show_balance  out  1  one-cycle pulse after balance op
ready  out  1  high in IDLE
session_active  out  1  high in PIN_WAIT..DISPENSE
card_eject  out  1  high in EJECT
card_retain  out  1  one-cycle pulse on lockout
error  out  1  one-cycle pulse with error_code
error_code  out  3  0 none, 1 bad PIN, 2 locked, 3 insufficient, 4 overflow, 5 timeout, 6 limit

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, balance=BAL_INIT, tries=0, timer=0.
  - All outputs 0 except ready=1.
  - Reset mid-dispense drops dispense_req immediately; no balance change.
- All outputs registered; every response appears one cycle after the causing input edge.
- IDLE: on card_in=1 go to PIN_WAIT; tries=0.
- PIN_WAIT, on pin_valid:
  - pin_value==stored_pin: go to MENU, tries=0.
  - Mismatch with tries+1 < MAX_PIN_TRIES: tries++, error pulse code 1, stay in PIN_WAIT.
  - Mismatch with tries+1 == MAX_PIN_TRIES: card_retain pulse, error code 2, go to IDLE.
- MENU, on op_valid:
  - op 00: show_balance pulse with balance_out=balance; stay in MENU.
  - op 01, amount==0: ignored, stay in MENU.
  - op 01, amount>balance: error code 3, stay in MENU.
  - op 01 otherwise: go to DISPENSE, latch cash_amount=amount.
  - op 10: if balance+amount overflows AMT_WIDTH bits, error code 4 and no change; else balance+=amount and deposit_complete pulse. Stay in MENU.
  - op 11: go to EJECT.
- DISPENSE:
  - dispense_req=1 until dispense_ack.
  - On dispense_ack: balance-=cash_amount, dispense_req drops the next cycle, go to MENU.
  - card_in and op_valid are ignored in this state.
- EJECT: card_eject=1 until card_in=0, then IDLE.
- Card removed (card_in=0) in PIN_WAIT or MENU: go to IDLE immediately, no error.
- Timeout:
  - Timer clears on state entry and on any pin_valid/op_valid/dispense_ack.
  - Timer increments otherwise in PIN_WAIT, MENU and DISPENSE.
  - At TIMEOUT_CYCLES-1: error code 5, go to EJECT. From DISPENSE, dispense_req drops and balance is unchanged.
- Simultaneous pin_valid and card_in falling edge: removal wins.
- op_valid outside MENU: ignored.
- Balance arithmetic is unsigned and never wraps.

Optional Feature:
ATM_SESSION_LIMIT_EN:
- Defined:
  - Parameter SESSION_LIMIT (default 500).
  - A session withdrawal accumulator, cleared on entry to PIN_WAIT.
  - A withdraw where accum+amount > SESSION_LIMIT gives error code 6 and stays in MENU.
  - The insufficient-balance check (code 3) takes priority over code 6.
  - On dispense_ack, accum+=cash_amount.
- Undefined: no accumulator and no code 6; the rest of the behaviour is identical.

Decomposition:
- Package atm_pkg holds:
  - state enum: IDLE, PIN_WAIT, MENU, DISPENSE, EJECT
  - op_code constants: OP_BAL, OP_WDR, OP_DEP, OP_EXIT
  - error_code constants: ERR_NONE .. ERR_LIMIT
- Sub-module atm_timeout_timer: parameterized counter with clear, enable and one-cycle expire output.

Test Plan:
- Reset with BAL_INIT=100; card_in=1, correct PIN, op 00 -> show_balance pulse with balance_out=100.
- 3 wrong PINs -> error code 1 twice, then card_retain pulse plus error code 2, back to IDLE with ready=1.
- Balance 100, withdraw 150 -> error code 3; withdraw 40 -> dispense_req held 5 cycles until ack, then balance=60 and state MENU.
- Balance 65500 (16-bit), deposit 100 -> error code 4, balance unchanged; deposit 35 -> deposit_complete pulse, balance=65535.
- TIMEOUT_CYCLES=16, no input in MENU -> error code 5 on cycle 16 and card_eject=1; card_in=0 -> IDLE.
- ATM_SESSION_LIMIT_EN with SESSION_LIMIT=500, balance 1000: withdraw 300 acked, then withdraw 300 -> error code 6, balance=700.
